// File: rtl/axi_node_w_sequencer.sv
// W-channel sequencer for one AXI node slave port: queues AW-grant master indices
// and routes W handshakes from the head master. Optional macro: AXI_NODE_W_SEQ_BYPASS_EN.
module axi_node_w_sequencer #(
    parameter int N_MASTER = 4,
    parameter int DEPTH    = 4,
    localparam int IDX_W   = (N_MASTER > 1) ? $clog2(N_MASTER) : 1,
    localparam int CNT_W   = ($clog2(DEPTH + 1) > 1) ? $clog2(DEPTH + 1) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                aw_grant_valid_i,
    input  logic [IDX_W-1:0]    aw_grant_idx_i,
    output logic                aw_grant_ready_o,
    input  logic [N_MASTER-1:0] inp_wvalid_i,
    input  logic [N_MASTER-1:0] inp_wlast_i,
    output logic [N_MASTER-1:0] inp_wready_o,
    output logic                oup_wvalid_o,
    output logic                oup_wlast_o,
    input  logic                oup_wready_i,
    output logic [IDX_W-1:0]    w_sel_o,
    output logic                w_sel_valid_o,
    output logic [CNT_W-1:0]    count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             bypass;
    logic             active;
    logic [IDX_W-1:0] head;
    logic             push, pop, fifo_push, fifo_pop;
    logic             head_wvalid, head_wlast;

    always_comb begin
`ifdef AXI_NODE_W_SEQ_BYPASS_EN
        // Empty-FIFO fall-through: the grant being made this cycle acts as head.
        bypass = (count_q == '0) && aw_grant_valid_i && !rst_i;
`else
        bypass = 1'b0;
`endif
        active           = (count_q != '0) || bypass;
        head             = bypass ? aw_grant_idx_i : mem_q[rd_ptr_q];
        aw_grant_ready_o = (count_q != FULL_CNT);

        head_wvalid  = 1'b0;
        head_wlast   = 1'b0;
        inp_wready_o = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (head == IDX_W'(i)) begin
                head_wvalid     = inp_wvalid_i[i];
                head_wlast      = inp_wlast_i[i];
                inp_wready_o[i] = active && oup_wready_i;
            end
        end

        w_sel_valid_o = active;
        w_sel_o       = active ? head : '0;
        oup_wvalid_o  = active && head_wvalid;
        oup_wlast_o   = active && head_wlast;

        push = aw_grant_valid_i && aw_grant_ready_o;
        pop  = oup_wvalid_o && oup_wready_i && oup_wlast_o;
        // A fall-through grant that completes its burst at once never touches the FIFO.
        fifo_push = push && !(bypass && pop);
        fifo_pop  = pop && !bypass;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_push) begin
            mem_d[wr_ptr_q] = aw_grant_idx_i;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (fifo_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign count_o = count_q;

`ifndef SYNTHESIS
    // A grant index outside the master range is a protocol violation upstream.
    idx_in_range_a: assert property (@(posedge clk_i) disable iff (rst_i)
        aw_grant_valid_i |-> (32'(aw_grant_idx_i) < N_MASTER));
`endif

endmodule

// File: doc/axi_node_w_sequencer.md
Name: axi_node_w_sequencer

Overview:
- Controls the W channel of one slave port in the AXI node.
- Records the order in which AW bursts were granted by the AW arbiter in a small FIFO of master indices.
- Routes W beats from exactly one master at a time, in AW-grant order, and advances to the next index when a beat with wlast completes.
- Drives only the handshake and the mux select. The W payload mux is external and is steered by w_sel_o.

Parameters:
- N_MASTER, 4, number of masters competing for this slave port (>=1).
- DEPTH, 4, number of outstanding AW grants whose W bursts are not yet complete (>=1, any integer, not limited to powers of two).
- IDX_W, derived localparam = max(1, $clog2(N_MASTER)), width of a master index.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- aw_grant_valid_i  in  1  AW arbiter has granted a burst (AW handshake toward the slave occurs this cycle).
- aw_grant_idx_i  in  IDX_W  index of the granted master.
- aw_grant_ready_o  out  1  FIFO can accept a grant; the AW arbiter must stall while this is low.
- inp_wvalid_i  in  N_MASTER  per-master wvalid.
- inp_wlast_i  in  N_MASTER  per-master wlast.
- inp_wready_o  out  N_MASTER  per-master wready.
- oup_wvalid_o  out  1  wvalid toward the slave.
- oup_wlast_o  out  1  wlast toward the slave.
- oup_wready_i  in  1  wready from the slave.
- w_sel_o  out  IDX_W  select for the external W data mux.
- w_sel_valid_o  out  1  w_sel_o is meaningful (a burst is active).
- count_o  out  $clog2(DEPTH+1) (min 1)  number of stored grants.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset, taken on a clock edge with rst_i=1:
  - wr_ptr, rd_ptr and count are cleared to 0.
  - Outputs after reset: aw_grant_ready_o=1, w_sel_valid_o=0, w_sel_o=0, oup_wvalid_o=0, oup_wlast_o=0, inp_wready_o=0, count_o=0.
  - Reset mid-burst drops all stored grants; no beat is forwarded in the cycle after reset.
- FIFO:
  - Circular buffer of DEPTH index entries. Pointers wrap from DEPTH-1 to 0.
  - aw_grant_ready_o = (count != DEPTH). It is combinational and independent of aw_grant_valid_i.
  - push = aw_grant_valid_i & aw_grant_ready_o.
  - Head entry is mem[rd_ptr]; active = (count != 0).
- Routing, all combinational from registered state:
  - w_sel_valid_o = active.
  - w_sel_o = head if active, else 0.
  - oup_wvalid_o = active & inp_wvalid_i[head].
  - oup_wlast_o = active & inp_wlast_i[head].
  - inp_wready_o[head] = active & oup_wready_i; all other bits are 0.
  - No valid-to-ready dependency is introduced; wready passes through unregistered.
- pop = oup_wvalid_o & oup_wready_i & oup_wlast_o.
- Count update per cycle:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged; both pointers advance.
- Boundary conditions:
  - Full: no push, even if a pop happens in the same cycle (no full-bypass). The grant is accepted on the next cycle.
  - Empty: a pushed grant becomes head in the next cycle, so push-to-first-beat latency is 1 cycle (unless the optional feature is enabled).
  - W beats arriving before their AW grant, or from a non-head master, are held with wready=0.
  - Same master granted twice in a row: its bursts are served back-to-back. On the cycle after its first wlast handshake, the head is the second entry.
  - Single-beat bursts (wlast on the first beat) pop after one beat.
- Indices >= N_MASTER on aw_grant_idx_i are a protocol violation. A simulation-only assertion checks this; hardware behaviour for such indices is undefined.

Optional Feature:
- Macro: AXI_NODE_W_SEQ_BYPASS_EN.
- Defined (empty-FIFO fall-through): when count==0 and aw_grant_valid_i=1, head = aw_grant_idx_i and active=1 in the same cycle, so W can complete in the grant cycle.
  - If that cycle also completes a wlast beat, the grant is consumed without being written: count stays 0 and pointers are unchanged.
  - Otherwise the grant is written normally.
  - aw_grant_ready_o is unaffected.
- Not defined: behaviour exactly as in Behaviour; first beat follows the grant by at least one cycle.

Test Plan:
- Reset check: hold rst_i=1 for 2 cycles with all inputs toggling -> every output at its reset value; count_o=0; aw_grant_ready_o=1.
- Ordering: N_MASTER=4; grant m2, then m0. Both masters present 3-beat bursts with wvalid=1 and oup_wready_i=1 -> beats m2,m2,m2(last), then m0,m0,m0(last). inp_wready_o[0] stays 0 until m2's last beat has completed; count_o goes 1,2,2,1,1,1,0.
- Full: DEPTH=4; push 4 grants with no W traffic -> aw_grant_ready_o=0 and count_o=4. A fifth grant held valid is accepted exactly one cycle after the first wlast pop.
- Back-pressure: oup_wready_i=0 for 5 cycles during m1's burst -> oup_wvalid_o=1 is held; no pop; inp_wready_o=0; w_sel_o stays 1.
- Wrap and simultaneous events: 10 single-beat bursts with push and pop in the same cycle at count=1 -> count_o stays 1, indices are delivered in order across the pointer wrap, no beat is lost or duplicated.
- Bypass (macro defined): empty FIFO; grant m3 in the same cycle as m3's single-beat burst -> oup_wvalid_o=1 and oup_wlast_o=1 in that cycle, count_o remains 0. Without the macro, the beat appears in the next cycle.
